// File: rtl/ram_march_bist.sv
// March C- built-in self-test engine driving the shared address port of a
// single-port RAM. Runs six march elements over every address, checks each
// read one cycle after issue, and reports pass/fail with the first failing
// location, element and bit pattern.
module ram_march_bist #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Start,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Pass,
    output logic [AW-1:0]    o_Fail_Addr,
    output logic [2:0]       o_Fail_Elem,
    output logic [WIDTH-1:0] o_Fail_Bits,
    output logic [AW-1:0]    o_Addr,
    output logic             o_Wr_DV,
    output logic [WIDTH-1:0] o_Wr_Data,
    output logic             o_Rd_En,
    input  logic             i_Rd_DV,
    input  logic [WIDTH-1:0] i_Rd_Data
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state;
    logic [2:0]       elem;       // element of the operation currently on the port
    logic             pend;       // a read was issued last cycle and is checked now
    logic [WIDTH-1:0] chk_exp;
    logic [AW-1:0]    chk_addr;
    logic [2:0]       chk_elem;

    logic             cur_down;
    logic             nxt_down;
    logic             at_last;
    logic             end_of_test;
    logic [2:0]       nxt_elem;
    logic [AW-1:0]    nxt_addr;
    logic             miscompare;

    // Background written by an element: E1 and E3 write ones, the rest zeros.
    function automatic logic [WIDTH-1:0] wr_bg(input logic [2:0] e);
        return (e == 3'd1 || e == 3'd3) ? '1 : '0;
    endfunction

    // Background expected on read: E2 and E4 expect ones, the rest zeros.
    function automatic logic [WIDTH-1:0] rd_bg(input logic [2:0] e);
        return (e == 3'd2 || e == 3'd4) ? '1 : '0;
    endfunction

    // Next-operation sequencing and read-check decision for the current cycle.
    always_comb begin
        cur_down    = (elem == 3'd3) || (elem == 3'd4);
        at_last     = cur_down ? (o_Addr == '0) : (o_Addr == LAST_ADDR);
        end_of_test = at_last && (elem == 3'd5);
        nxt_elem    = at_last ? 3'(elem + 3'd1) : elem;
        nxt_down    = (nxt_elem == 3'd3) || (nxt_elem == 3'd4);
        if (at_last) begin
            nxt_addr = nxt_down ? LAST_ADDR : '0;
        end else begin
            nxt_addr = cur_down ? AW'(o_Addr - 1'b1) : AW'(o_Addr + 1'b1);
        end
        miscompare = pend && (!i_Rd_DV || (i_Rd_Data != chk_exp));
    end

    // Control FSM with registered RAM strobes, status and check pipeline.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            elem        <= '0;
            pend        <= 1'b0;
            chk_exp     <= '0;
            chk_addr    <= '0;
            chk_elem    <= '0;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
            o_Pass      <= 1'b0;
            o_Fail_Addr <= '0;
            o_Fail_Elem <= '0;
            o_Fail_Bits <= '0;
            o_Addr      <= '0;
            o_Wr_DV     <= 1'b0;
            o_Wr_Data   <= '0;
            o_Rd_En     <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            pend   <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    if (i_Start) begin
                        state       <= RUN;
                        elem        <= '0;
                        o_Addr      <= '0;
                        o_Wr_DV     <= 1'b1;
                        o_Wr_Data   <= '0;
                        o_Rd_En     <= 1'b0;
                        o_Busy      <= 1'b1;
                        o_Pass      <= 1'b0;
                        o_Fail_Addr <= '0;
                        o_Fail_Elem <= '0;
                        o_Fail_Bits <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    chk_exp  <= rd_bg(elem);
                    chk_addr <= o_Addr;
                    chk_elem <= elem;
                    if (miscompare) begin
                        // The operation on the port this cycle is dropped and never checked.
                        state       <= FINISH;
                        o_Fail_Addr <= chk_addr;
                        o_Fail_Elem <= chk_elem;
                        o_Fail_Bits <= chk_exp ^ i_Rd_Data;
                        o_Wr_DV     <= 1'b0;
                        o_Rd_En     <= 1'b0;
                        o_Busy      <= 1'b0;
                        o_Done      <= 1'b1;
                        o_Pass      <= 1'b0;
                    end else if (end_of_test) begin
                        pend    <= o_Rd_En;
                        state   <= DRAIN;
                        o_Wr_DV <= 1'b0;
                        o_Rd_En <= 1'b0;
                    end else begin
                        pend      <= o_Rd_En;
                        elem      <= nxt_elem;
                        o_Addr    <= nxt_addr;
                        o_Wr_DV   <= (nxt_elem != 3'd5);
                        o_Rd_En   <= (nxt_elem != 3'd0);
                        o_Wr_Data <= (nxt_elem == 3'd5) ? '0 : wr_bg(nxt_elem);
                    end
                end
                DRAIN: begin
                    state  <= FINISH;
                    o_Busy <= 1'b0;
                    o_Done <= 1'b1;
                    o_Pass <= !miscompare;
                    if (miscompare) begin
                        o_Fail_Addr <= chk_addr;
                        o_Fail_Elem <= chk_elem;
                        o_Fail_Bits <= chk_exp ^ i_Rd_Data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist with DEPTH=8: behavioural RAM with
// selectable faults, per-cycle port monitor and hand-derived expectations.
module tb_ram_march_bist;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             busy, done, pass;
    logic [AW-1:0]    fail_addr;
    logic [2:0]       fail_elem;
    logic [WIDTH-1:0] fail_bits;
    logic [AW-1:0]    addr;
    logic             wr_dv, rd_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_dv;
    logic [WIDTH-1:0] rd_data;

    int pass_cnt = 0;
    int total    = 0;

    // 0 = fault-free, 1 = bit 3 of address 5 stuck at 0,
    // 2 = writes to address 6 also land in address 2, 3 = read-valid never returned
    int mode = 0;

    always #5 clk = ~clk;

    ram_march_bist #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Start     (start),
        .o_Busy      (busy),
        .o_Done      (done),
        .o_Pass      (pass),
        .o_Fail_Addr (fail_addr),
        .o_Fail_Elem (fail_elem),
        .o_Fail_Bits (fail_bits),
        .o_Addr      (addr),
        .o_Wr_DV     (wr_dv),
        .o_Wr_Data   (wr_data),
        .o_Rd_En     (rd_en),
        .i_Rd_DV     (rd_dv),
        .i_Rd_Data   (rd_data)
    );

    // Behavioural single-port RAM: one-cycle read latency, read returns pre-write data.
    logic [WIDTH-1:0] mem [DEPTH];

    function automatic logic [WIDTH-1:0] ram_read(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = mem[a];
        if (mode == 1 && a == 3'd5) v[3] = 1'b0;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dv   <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_dv   <= rd_en && (mode != 3);
            rd_data <= (rd_en && mode != 3) ? ram_read(addr) : '0;
            if (wr_dv) begin
                mem[addr] <= wr_data;
                if (mode == 2 && addr == 3'd6) mem[2] <= wr_data;
            end
        end
    end

    // Port monitor, sampled on the falling edge.
    int busy_cnt  = 0;
    int done_cnt  = 0;
    int stray_cnt = 0;
    logic [20:0] op_q [$];

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (wr_dv || rd_en) begin
            if (!busy) stray_cnt++;
            op_q.push_back({addr, wr_dv, rd_en, (wr_dv ? wr_data : 16'h0000)});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One test run: start pulse, first-cycle checks, bounded wait for o_Done.
    task automatic run_test(input string tag, input int restart_at,
                            output int busy_d, output int done_d,
                            output int stray_d, output int base);
        int b0, d0, s0;
        bit seen;
        b0   = busy_cnt;
        d0   = done_cnt;
        s0   = stray_cnt;
        base = op_q.size();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, "_first_cycle"}, {busy, wr_dv, rd_en, addr, wr_data}, {3'b110, 3'd0, 16'h0000});
        chk({tag, "_cleared"}, {pass, fail_addr, fail_elem, fail_bits}, '0);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            start = (restart_at > 0 && k == restart_at);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        busy_d  = busy_cnt - b0;
        done_d  = done_cnt - d0;
        stray_d = stray_cnt - s0;
    endtask

    initial begin
        int bd, dd, sd, base;
        int e, j;
        logic [2:0] ea;
        logic [20:0] exp_op;

        rst_n = 1'b0;
        start = 1'b0;
        #12;
        chk("reset_ctrl", {busy, done, pass, wr_dv, rd_en}, '0);
        chk("reset_fail", {fail_addr, fail_elem, fail_bits}, '0);
        chk("reset_port", {addr, wr_data}, '0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fault-free run: 48 RUN cycles plus one DRAIN cycle.
        mode = 0;
        run_test("pass", 0, bd, dd, sd, base);
        chk("pass_busy", bd, 49);
        chk("pass_done", dd, 1);
        chk("pass_stray", sd, 0);
        chk("pass_result", {pass, fail_addr, fail_elem, fail_bits}, {1'b1, 22'd0});
        chk("pass_opcount", op_q.size() - base, 48);
        for (int i = 0; i < 48; i++) begin
            e  = i / 8;
            j  = i % 8;
            ea = (e == 3 || e == 4) ? 3'(7 - j) : 3'(j);
            exp_op = {ea, (e != 5), (e != 0), ((e == 1 || e == 3) ? 16'hFFFF : 16'h0000)};
            chk($sformatf("op_%0d", i), op_q[base + i], exp_op);
        end

        // Second start mid-run is ignored.
        run_test("restart", 20, bd, dd, sd, base);
        chk("restart_busy", bd, 49);
        chk("restart_done", dd, 1);
        chk("restart_pass", pass, 1);

        // Stuck-at-0 on bit 3 of address 5: first seen by E2 reading ones.
        // E2 addr 5 issued in cycle 22, checked in cycle 23.
        mode = 1;
        run_test("stuck", 0, bd, dd, sd, base);
        chk("stuck_pass", pass, 0);
        chk("stuck_elem", fail_elem, 2);
        chk("stuck_addr", fail_addr, 5);
        chk("stuck_bits", fail_bits, 16'h0008);
        chk("stuck_busy", bd, 23);
        chk("stuck_stray", sd, 0);
        chk("stuck_done", dd, 1);

        // Writes to 6 alias into 2: E1/E2 write 2 before 6 in ascending order so
        // they agree; E3 descends, writes ones via 6, then reads 2 expecting zeros.
        // E3 addr 2 is op 29 (cycle 30), checked in cycle 31.
        mode = 2;
        run_test("decode", 0, bd, dd, sd, base);
        chk("decode_pass", pass, 0);
        chk("decode_elem", fail_elem, 3);
        chk("decode_addr", fail_addr, 2);
        chk("decode_bits", fail_bits, 16'hFFFF);
        chk("decode_busy", bd, 31);
        chk("decode_stray", sd, 0);

        // Read-valid never returned: first read is E1 addr 0 (cycle 9), fails in cycle 10.
        mode = 3;
        run_test("nodv", 0, bd, dd, sd, base);
        chk("nodv_pass", pass, 0);
        chk("nodv_elem", fail_elem, 1);
        chk("nodv_addr", fail_addr, 0);
        chk("nodv_bits", fail_bits, 0);
        chk("nodv_busy", bd, 10);
        chk("nodv_stray", sd, 0);

        // Asynchronous reset in the middle of E3.
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (26) @(negedge clk);
        chk("midE3_port", {busy, wr_dv, rd_en, addr}, {3'b111, 3'd5});
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {busy, done, pass, wr_dv, rd_en}, '0);
        chk("midrst_port", {addr, wr_data, fail_addr, fail_elem, fail_bits}, '0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_test("after_rst", 0, bd, dd, sd, base);
        chk("after_rst_busy", bd, 49);
        chk("after_rst_pass", pass, 1);
        chk("after_rst_done", dd, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
